// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-RAM arbiter: FSM states, access owner and
// the byte-enable width helper used by the interface and top.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports plus the single RAM port as one bundle.
// slave = arbiter side, master = CPU and RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int BE_W = mem_arb_pkg::be_width(DATA_W);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection (data first) with a starvation counter that forces a
// fetch grant after STARVE_MAX consecutive data grants while fetch waits.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   excl_if_i,
  input  logic   excl_d_i,
  input  logic   grant_i,
  output owner_e winner_o,
  output logic   valid_pick_o
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_act, d_act;

  // The owner of a just-completed access still holds req during DONE.
  assign if_act       = if_req_i && !excl_if_i;
  assign d_act        = d_req_i && !excl_d_i;
  assign valid_pick_o = if_act || d_act;

  always_comb begin
    winner_o = OWN_D;
    if (if_act && (!d_act || starve_cnt_q == SMAX)) winner_o = OWN_IF;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i) starve_cnt_d = '0;
    else if (grant_i && winner_o == OWN_IF) starve_cnt_d = '0;
    else if (grant_i && starve_cnt_q != SMAX) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and data: issue, wait RAM_LAT,
// pulse valid (issue at T -> valid at T+RAM_LAT+1); requesters stall meanwhile.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_W = be_width(DATA_W);
  localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

  state_e            state_q;
  owner_e            owner_q;
  logic              owner_we_q;
  logic [1:0]        lat_cnt_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_valid_q, d_valid_q;

  owner_e            winner;
  logic              pick_vld, issue, in_done;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [BE_W-1:0]   we_mux;

  assign in_done = (state_q == DONE);

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .excl_if_i    (in_done && owner_q == OWN_IF),
    .excl_d_i     (in_done && owner_q == OWN_D),
    .grant_i      (issue),
    .winner_o     (winner),
    .valid_pick_o (pick_vld)
  );

  assign issue = !rst && pick_vld && (state_q == IDLE || in_done);

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = '0;
    if (issue) begin
      if (winner == OWN_D) begin
        addr_mux  = bus.d_addr;
        wdata_mux = bus.d_wdata;
        if (bus.d_we) we_mux = bus.d_be;
      end else begin
        addr_mux = bus.if_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      owner_we_q <= 1'b0;
      lat_cnt_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (issue) begin
            owner_q    <= winner;
            owner_we_q <= (winner == OWN_D) && bus.d_we;
            lat_cnt_q  <= LAT_INIT;
            state_q    <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (lat_cnt_q == 2'd0) begin
            if (owner_q == OWN_IF) begin
              if_rdata_q <= bus.ram_rdata;
              if_valid_q <= 1'b1;
            end else begin
              if (!owner_we_q) d_rdata_q <= bus.ram_rdata;
              d_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so nothing stale leaks out while reset is held.
  assign bus.if_valid  = if_valid_q && !rst;
  assign bus.d_valid   = d_valid_q && !rst;
  assign bus.if_rdata  = rst ? '0 : if_rdata_q;
  assign bus.d_rdata   = rst ? '0 : d_rdata_q;
  assign bus.if_stall  = bus.if_req && !bus.if_valid;
  assign bus.d_stall   = bus.d_req && !bus.d_valid;
  assign bus.ram_en    = issue;
  assign bus.ram_we    = we_mux;
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_wdata = wdata_mux;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: cycle table on a RAM_LAT=1 arbiter, plus reset, starvation
// and RAM_LAT=3 sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] I0   = 32'h00500093;
  localparam logic [31:0] I1   = 32'h11111111;
  localparam logic [31:0] I2   = 32'h22222222;
  localparam logic [31:0] BEEF = 32'hDEADBEEF;
  localparam logic [31:0] CAFE = 32'hDEADCAFE;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .STARVE_MAX(3)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .STARVE_MAX(3)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  logic   p_if, p_d, p_xi, p_xd, p_g, p_vld;
  owner_e p_win;
  mem_arb_pick #(.STARVE_MAX(3)) pick (
    .clk (clk), .rst (rst), .if_req_i (p_if), .d_req_i (p_d), .excl_if_i (p_xi),
    .excl_d_i (p_xd), .grant_i (p_g), .winner_o (p_win), .valid_pick_o (p_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behind dut_a: one-cycle synchronous read, byte-masked write.
  logic [31:0] mem_a [0:255];
  logic [31:0] a_rd;
  always @(posedge clk) begin
    if (bus_a.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus_a.ram_we[b]) mem_a[bus_a.ram_addr[9:2]][8*b +: 8] <= bus_a.ram_wdata[8*b +: 8];
      if (bus_a.ram_we == 4'h0) a_rd <= mem_a[bus_a.ram_addr[9:2]];
    end
  end
  assign bus_a.ram_rdata = a_rd;

  // RAM behind dut_b: three-cycle read pipeline, contents = addr ^ A5A50000.
  logic [31:0] b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    if (bus_b.ram_en) b_p0 <= bus_b.ram_addr ^ 32'hA5A50000;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign bus_b.ram_rdata = b_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic ir; logic [31:0] ia; logic dr; logic dwe; logic [3:0] dbe;
    logic [31:0] da; logic [31:0] dwd;
    logic en; logic [3:0] rwe; logic [31:0] ra; logic iv; logic [31:0] ird;
    logic dv; logic [31:0] drd; logic ist; logic dst;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int iss[3];
    int vld[3];
    int ni, nv, lat;
    logic got, prev_v;
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_be = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_be = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
    p_if = 0; p_d = 0; p_xi = 0; p_xd = 0; p_g = 0;
    for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
    a_rd <= 32'h0;
    mem_a[4] <= I0; mem_a[5] <= I1; mem_a[6] <= I2;
    iss = '{0, 0, 0}; vld = '{0, 0, 0};

    //           rst ir ia     dr we be    da      wd          en we    ra      iv ird dv drd  ist dst
    vecs.push_back('{1, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0});
    vecs.push_back('{0, 1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        1, 4'h0, 32'h10,  0, 32'h0, 0, 32'h0, 1, 0});
    vecs.push_back('{0, 1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 0});
    vecs.push_back('{0, 1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   1, I0,    0, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, I0,    0, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'hF, 32'h100, BEEF,         1, 4'hF, 32'h100, 0, I0,    0, 32'h0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'hF, 32'h100, BEEF,         0, 4'h0, 32'h0,   0, I0,    0, 32'h0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'hF, 32'h100, BEEF,         0, 4'h0, 32'h0,   0, I0,    1, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        1, 4'h0, 32'h100, 0, I0,    0, 32'h0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I0,    0, 32'h0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I0,    1, BEEF,  0, 0});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'h3, 32'h100, 32'h0000CAFE, 1, 4'h3, 32'h100, 0, I0,    0, BEEF,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'h3, 32'h100, 32'h0000CAFE, 0, 4'h0, 32'h0,   0, I0,    0, BEEF,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 4'h3, 32'h100, 32'h0000CAFE, 0, 4'h0, 32'h0,   0, I0,    1, BEEF,  0, 0});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        1, 4'h0, 32'h100, 0, I0,    0, BEEF,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I0,    0, BEEF,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I0,    1, CAFE,  0, 0});
    vecs.push_back('{0, 1, 32'h14, 1, 0, 4'h0, 32'h100, 32'h0,        1, 4'h0, 32'h100, 0, I0,    0, CAFE,  1, 1});
    vecs.push_back('{0, 1, 32'h14, 1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I0,    0, CAFE,  1, 1});
    vecs.push_back('{0, 1, 32'h14, 1, 0, 4'h0, 32'h100, 32'h0,        1, 4'h0, 32'h14,  0, I0,    1, CAFE,  1, 0});
    vecs.push_back('{0, 1, 32'h14, 0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, I0,    0, CAFE,  1, 0});
    vecs.push_back('{0, 1, 32'h14, 0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   1, I1,    0, CAFE,  0, 0});
    vecs.push_back('{0, 1, 32'h18, 0, 0, 4'h0, 32'h0,   32'h0,        1, 4'h0, 32'h18,  0, I1,    0, CAFE,  1, 0});
    vecs.push_back('{0, 1, 32'h18, 1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I1,    0, CAFE,  1, 1});
    vecs.push_back('{0, 1, 32'h18, 1, 0, 4'h0, 32'h100, 32'h0,        1, 4'h0, 32'h100, 1, I2,    0, CAFE,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I2,    0, CAFE,  0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,   0, I2,    1, CAFE,  0, 0});
    vecs.push_back('{0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,   0, I2,    0, CAFE,  0, 0});

    // Internal reset state
    @(negedge clk); #1;
    check("reset state", 32'(dut_a.state_q), 32'(IDLE));
    check("reset lat_cnt", 32'(dut_a.lat_cnt_q), 0);
    check("reset starve_cnt", 32'(dut_a.u_pick.starve_cnt_q), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus_a.if_req = vecs[i].ir;  bus_a.if_addr = vecs[i].ia;
      bus_a.d_req  = vecs[i].dr;  bus_a.d_we    = vecs[i].dwe; bus_a.d_be = vecs[i].dbe;
      bus_a.d_addr = vecs[i].da;  bus_a.d_wdata = vecs[i].dwd;
      #1;
      check($sformatf("v%0d ram_en", i), 32'(bus_a.ram_en), 32'(vecs[i].en));
      check($sformatf("v%0d ram_we", i), 32'(bus_a.ram_we), 32'(vecs[i].rwe));
      if (vecs[i].en) check($sformatf("v%0d ram_addr", i), bus_a.ram_addr, vecs[i].ra);
      check($sformatf("v%0d if_valid", i), 32'(bus_a.if_valid), 32'(vecs[i].iv));
      check($sformatf("v%0d if_rdata", i), bus_a.if_rdata, vecs[i].ird);
      check($sformatf("v%0d d_valid", i), 32'(bus_a.d_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d d_rdata", i), bus_a.d_rdata, vecs[i].drd);
      check($sformatf("v%0d if_stall", i), 32'(bus_a.if_stall), 32'(vecs[i].ist));
      check($sformatf("v%0d d_stall", i), 32'(bus_a.d_stall), 32'(vecs[i].dst));
    end

    // Reset during BUSY discards the read
    @(negedge clk);
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_be = 0; bus_a.d_addr = 32'h100;
    #1 check("rst-seq issue", 32'(bus_a.ram_en), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in-rst ram_en", 32'(bus_a.ram_en), 0);
    check("in-rst ram_we", 32'(bus_a.ram_we), 0);
    check("in-rst d_valid", 32'(bus_a.d_valid), 0);
    check("in-rst d_rdata", bus_a.d_rdata, 0);
    check("in-rst if_rdata", bus_a.if_rdata, 0);
    check("in-rst d_stall", 32'(bus_a.d_stall), 1);
    @(negedge clk);
    rst = 1'b0; bus_a.d_req = 0;
    #1;
    check("post-rst d_valid", 32'(bus_a.d_valid), 0);
    check("post-rst ram_en", 32'(bus_a.ram_en), 0);
    check("post-rst d_rdata", bus_a.d_rdata, 0);
    check("post-rst state", 32'(dut_a.state_q), 32'(IDLE));
    @(negedge clk);
    bus_a.d_req = 1;
    #1 check("fresh issue", 32'(bus_a.ram_en), 1);
    got = 0; lat = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk); #1;
      if (bus_a.d_valid) begin got = 1; lat = c; end
    end
    check("fresh d_valid seen", 32'(got), 1);
    check("fresh latency", lat, 2);
    check("fresh d_rdata", bus_a.d_rdata, CAFE);
    @(negedge clk);
    bus_a.d_req = 0;

    // Starvation: three data grants, then fetch is forced
    p_if = 1; p_d = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p_g = 1;
      #1;
      check($sformatf("starve cnt before grant %0d", k), 32'(pick.starve_cnt_q), k);
      check($sformatf("starve winner %0d", k), 32'(p_win), (k < 3) ? 32'(OWN_D) : 32'(OWN_IF));
      check($sformatf("starve valid %0d", k), 32'(p_vld), 1);
    end
    @(negedge clk);
    p_g = 0;
    #1 check("starve cleared by IF grant", 32'(pick.starve_cnt_q), 0);
    p_xd = 1;
    #1 check("excluded D lets IF win", 32'(p_win), 32'(OWN_IF));
    p_xd = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      p_g = 1;
    end
    @(negedge clk);
    p_g = 0;
    #1 check("starve after two D grants", 32'(pick.starve_cnt_q), 2);
    p_if = 0;
    @(negedge clk); #1;
    check("starve cleared by if_req low", 32'(pick.starve_cnt_q), 0);
    p_d = 0;
    #1 check("no pick when idle", 32'(p_vld), 0);

    // RAM_LAT=3: latency 4, back-to-back issue every 5 cycles
    ni = 0; nv = 0; prev_v = 0;
    for (int c = 0; c < 40 && nv < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus_b.if_req = 1; bus_b.if_addr = 32'h20;
      end else if (prev_v) begin
        bus_b.if_addr = bus_b.if_addr + 32'h4;
      end
      #1;
      prev_v = bus_b.if_valid;
      if (bus_b.ram_en && ni < 3) begin
        iss[ni] = c;
        check($sformatf("L3 issue addr %0d", ni), bus_b.ram_addr, 32'h20 + 32'(4 * ni));
        ni++;
      end
      if (bus_b.if_valid) begin
        vld[nv] = c;
        check($sformatf("L3 if_rdata %0d", nv), bus_b.if_rdata,
              (32'h20 + 32'(4 * nv)) ^ 32'hA5A50000);
        nv++;
      end
    end
    @(negedge clk);
    bus_b.if_req = 0;
    check("L3 completions", nv, 3);
    for (int i = 0; i < 3; i++) check($sformatf("L3 latency %0d", i), vld[i] - iss[i], 4);
    for (int i = 0; i < 2; i++) check($sformatf("L3 issue spacing %0d", i), iss[i+1] - iss[i], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified RAM between the CPU's instruction-fetch port and its data-access port.
- Sits between the cpu top and the RAM. It replaces the separate instruction and data memories with one physical array.
- Sequences each access through a fixed-latency RAM, returns read data and a completion pulse to each side, and generates stall signals for the pipeline.
- Data accesses win by default. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RAM_LAT, 1, RAM read latency in cycles, range 1..4.
- STARVE_MAX, 3, maximum consecutive data grants while if_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched instruction; meaningful when if_valid
- if_valid  out  1  one-cycle completion pulse
- if_stall  out  1  if_req && !if_valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  write byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  load data; meaningful when d_valid
- d_valid  out  1  one-cycle completion pulse (reads and writes)
- d_stall  out  1  d_req && !d_valid
- ram_en  out  1  RAM access strobe, issue cycle only
- ram_we  out  DATA_W/8  per-byte write enable, issue cycle only
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, RAM_LAT cycles after issue

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high: clk, rst.
- FSM states: IDLE, BUSY, DONE.
- Per-state behaviour:
  - IDLE:
    - Choose a winner among active requests; if one exists, issue in this cycle.
    - Issue drives ram_en=1, ram_addr/ram_wdata from the winner, ram_we = d_we ? d_be : 0.
    - Latch the owner (IF or D).
    - Load lat_cnt = RAM_LAT-1 and go to BUSY.
  - BUSY:
    - ram_en=0, ram_we=0.
    - Decrement lat_cnt.
    - When lat_cnt==0, register ram_rdata into the owner's rdata register and go to DONE.
  - DONE:
    - Owner's *_valid=1 for exactly this cycle.
    - The non-owner may issue in this cycle (same rules as IDLE). The owner may not, because its req is still high for its completed access.
    - Next state is BUSY if an issue occurred, else IDLE.
- Timing and throughput:
  - Issue at cycle T → valid in cycle T+RAM_LAT+1.
  - Sustained single-requester throughput is one access per RAM_LAT+2 cycles.
- Arbitration:
  - Default priority is D over IF.
  - starve_cnt increments on each D grant while if_req=1. It clears on any IF grant, or when if_req=0.
  - When starve_cnt==STARVE_MAX and if_req=1, IF wins even if d_req=1.
- Writes: ram_rdata is ignored; d_rdata keeps its previous value; d_valid still pulses.
- rdata registers hold their value until the next completion for that port.
- Requester drops req mid-access (protocol violation): the access completes and valid still pulses. No abort.
- Outputs while rst=1 and on the first cycle after reset:
  - ram_en=0, ram_we=0.
  - if_valid=0, d_valid=0.
  - if_rdata=0, d_rdata=0.
  - state=IDLE, lat_cnt=0, starve_cnt=0.
- Reset asserted during BUSY or DONE discards the in-flight access; no valid pulse is produced.
- ram_addr/ram_wdata are don't-care when ram_en=0 but must not contain X after reset; drive 0.
- *_stall outputs are combinational from req and valid. They are 0 during reset only if req=0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - owner enum {OWN_IF, OWN_D}.
  - Function computing the byte-enable width from DATA_W.
- Sub-module mem_arb_pick:
  - Combinational winner selection plus the starvation counter register.
  - Inputs: if_req, d_req, the owner-exclusion flag from the DONE state, a grant strobe.
  - Outputs: winner, valid_pick.
- The FSM, latency counter and rdata registers live in mem_arbiter.

Test Plan (RAM_LAT=1, STARVE_MAX=3, behavioural RAM model):
1. Fetch only: if_req=1, if_addr=0x10, RAM[0x10]=0x00500093.
   - Required: ram_en at T, if_valid at T+2 with if_rdata=0x00500093.
   - Required: if_stall=1 at T and T+1, 0 at T+2.
2. Data write then read:
   - d_we=1, d_addr=0x100, d_be=0xF, d_wdata=0xDEADBEEF → d_valid at T+2.
   - Read of 0x100 → d_rdata=0xDEADBEEF.
   - d_be=0x3 write of 0x0000CAFE → read 0xDEADCAFE.
3. Simultaneous requests:
   - Both req at T → D issued at T, d_valid T+2.
   - IF issued at T+2 (DONE-cycle issue), if_valid T+4.
4. Starvation: if_req=1 held, d_req=1 held (re-asserted for new addresses).
   - Required: three D grants, then an IF grant.
   - Required: starve_cnt back to 0 after the IF grant.
5. Reset mid-access:
   - Issue D read, assert rst in the BUSY cycle → no d_valid.
   - All outputs 0 the next cycle.
   - Fresh request completes normally afterwards.
6. RAM_LAT=3 rebuild: single fetch issued at T → if_valid at T+4. Back-to-back fetches are issued every 5 cycles.
